// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if
//   Groups the requester-side and UART-side signals of uart_tx_arbiter.
//   Signal names match the original uart_tx_arbiter ports.
//   slave  : arbiter view (inputs i_req, i_data, i_tx_done; drives all o_*)
//   master : environment view (drives i_*, observes o_*)
interface uart_tx_arbiter_if #(
  parameter int unsigned NB_BITS = 8,
  parameter int unsigned N_REQ   = 2
);
  logic [N_REQ-1:0]         i_req;
  logic [N_REQ*NB_BITS-1:0] i_data;
  logic                     i_tx_done;
  logic [NB_BITS-1:0]       o_tx_data;
  logic                     o_tx_start;
  logic [N_REQ-1:0]         o_grant;
  logic [N_REQ-1:0]         o_done;
  logic                     o_timeout;
  logic                     o_busy;

  modport slave (
    input  i_req, i_data, i_tx_done,
    output o_tx_data, o_tx_start, o_grant, o_done, o_timeout, o_busy
  );

  modport master (
    output i_req, i_data, i_tx_done,
    input  o_tx_data, o_tx_start, o_grant, o_done, o_timeout, o_busy
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Round-robin share of one UART transmitter between N_REQ requesters.
//   The winner's byte is latched, o_tx_start is held until a rising edge of
//   i_tx_done, then the winner gets a one-cycle o_done pulse followed by a
//   guard cycle before the next arbitration.
// Ports
//   i_clk, i_rst : clock (rising edge), synchronous active-high reset
//   bus (slave)  : i_req, i_data, i_tx_done in; o_tx_data, o_tx_start,
//                  o_grant, o_done, o_timeout, o_busy out (all registered)
// Optional feature
//   ARB_TIMEOUT_EN : SEND watchdog of TIMEOUT_CYC cycles; without it SEND
//                    waits indefinitely and o_timeout is tied 0.
module uart_tx_arbiter #(
  parameter int unsigned NB_BITS = 8,
  parameter int unsigned N_REQ   = 2
`ifdef ARB_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYC = 200000
`endif
) (
  input logic              i_clk,
  input logic              i_rst,
  uart_tx_arbiter_if.slave bus
);

  localparam int unsigned RW = $clog2(N_REQ);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEND    = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t             state_q, state_n;
  logic [N_REQ-1:0]   grant_q, grant_n;
  logic [N_REQ-1:0]   done_q, done_n;
  logic [NB_BITS-1:0] data_q, data_n;
  logic               start_q, start_n;
  logic               busy_q, busy_n;
  logic [RW-1:0]      rr_q, rr_n;
  logic [RW-1:0]      owner_q, owner_n;
  logic               prev_q;
  logic               tx_edge;
  logic               pick_found;
  logic [RW-1:0]      pick;
  int unsigned        idx;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt_q, cnt_n;
  logic          timeout_q, timeout_n;
`endif

  assign tx_edge = bus.i_tx_done & ~prev_q;

  always_comb begin
    // Round-robin search starting just after the last served requester.
    pick_found = 1'b0;
    pick       = '0;
    idx        = 0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      idx = 32'(rr_q) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!pick_found && bus.i_req[idx]) begin
        pick_found = 1'b1;
        pick       = RW'(idx);
      end
    end

    state_n = state_q;
    grant_n = grant_q;
    done_n  = '0;
    data_n  = data_q;
    start_n = start_q;
    rr_n    = rr_q;
    owner_n = owner_q;
`ifdef ARB_TIMEOUT_EN
    cnt_n     = cnt_q;
    timeout_n = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          grant_n       = '0;
          grant_n[pick] = 1'b1;
          data_n        = bus.i_data[pick*NB_BITS +: NB_BITS];
          start_n       = 1'b1;
          owner_n       = pick;
          state_n       = ST_SEND;
`ifdef ARB_TIMEOUT_EN
          cnt_n         = '0;
`endif
        end
      end
      ST_SEND: begin
        if (tx_edge) begin
          start_n = 1'b0;
          done_n  = grant_q;
          rr_n    = owner_q;
          state_n = ST_RELEASE;
        end
`ifdef ARB_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
          start_n   = 1'b0;
          timeout_n = 1'b1;
          rr_n      = owner_q;
          state_n   = ST_RELEASE;
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
`endif
      end
      ST_RELEASE: begin
        grant_n = '0;
        state_n = ST_IDLE;
      end
      default: begin
        grant_n = '0;
        data_n  = '0;
        start_n = 1'b0;
        state_n = ST_IDLE;
      end
    endcase

    busy_n = (state_n != ST_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      done_q  <= '0;
      data_q  <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      rr_q    <= RW'(N_REQ - 1);
      owner_q <= '0;
      prev_q  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q <= state_n;
      grant_q <= grant_n;
      done_q  <= done_n;
      data_q  <= data_n;
      start_q <= start_n;
      busy_q  <= busy_n;
      rr_q    <= rr_n;
      owner_q <= owner_n;
      prev_q  <= bus.i_tx_done;
`ifdef ARB_TIMEOUT_EN
      cnt_q     <= cnt_n;
      timeout_q <= timeout_n;
`endif
    end
  end

  assign bus.o_tx_data  = data_q;
  assign bus.o_tx_start = start_q;
  assign bus.o_grant    = grant_q;
  assign bus.o_done     = done_q;
  assign bus.o_busy     = busy_q;
`ifdef ARB_TIMEOUT_EN
  assign bus.o_timeout  = timeout_q;
`else
  assign bus.o_timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
//   Self-checking bench for uart_tx_arbiter (NB_BITS=8, N_REQ=2). The bench
//   acts as both requesters and as the UART; expected winners come from a
//   last-served round-robin model, expected bytes from the bench's own data.
//   With ARB_TIMEOUT_EN the DUT is built with TIMEOUT_CYC=50.
module tb_uart_tx_arbiter;

  logic       clk;
  logic       rst;
  logic [1:0] req_v;
  logic [7:0] byte_v [2];
  logic       txd;

  int unsigned n_tests;
  int unsigned n_fail;
  int unsigned last_served;

  uart_tx_arbiter_if #(.NB_BITS(8), .N_REQ(2)) bus ();

  assign bus.i_req     = req_v;
  assign bus.i_data    = {byte_v[1], byte_v[0]};
  assign bus.i_tx_done = txd;

`ifdef ARB_TIMEOUT_EN
  uart_tx_arbiter #(.NB_BITS(8), .N_REQ(2), .TIMEOUT_CYC(50)) dut (
    .i_clk(clk), .i_rst(rst), .bus(bus.slave));
`else
  uart_tx_arbiter #(.NB_BITS(8), .N_REQ(2)) dut (
    .i_clk(clk), .i_rst(rst), .bus(bus.slave));
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Round-robin rule: first requester after the last served one.
  function automatic int unsigned model_pick(input logic [1:0] r);
    for (int unsigned k = 1; k <= 2; k++) begin
      if (r[(last_served + k) % 2]) return (last_served + k) % 2;
    end
    return 0;
  endfunction

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_start"}, bus.o_tx_start, 0);
    check_eq({tag, "_grant"}, bus.o_grant, 0);
    check_eq({tag, "_done"},  bus.o_done, 0);
    check_eq({tag, "_busy"},  bus.o_busy, 0);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_idle_outputs("rst");
    check_eq("rst_data", bus.o_tx_data, 0);
    check_eq("rst_timeout", bus.o_timeout, 0);
    rst = 1'b0;
    last_served = 1;
  endtask

  // Entry: at a negedge with the DUT idle and req_v nonzero.
  task automatic do_xfer(input bit pre_high, input bit drop_mid, input bit keep_req,
                         input int unsigned wait_c, output int unsigned served,
                         output logic [7:0] sent);
    int unsigned w;
    logic [7:0]  exp_b;
    logic [1:0]  oh;
    w     = model_pick(req_v);
    exp_b = byte_v[w];
    oh    = 2'(1 << w);
    if (pre_high) txd = 1'b1;
    @(negedge clk);
    sent = bus.o_tx_data;
    check_eq("x_start", bus.o_tx_start, 1);
    check_eq("x_grant", bus.o_grant, oh);
    check_eq("x_data",  bus.o_tx_data, exp_b);
    check_eq("x_busy",  bus.o_busy, 1);
    check_eq("x_nodone", bus.o_done, 0);
    if (pre_high) begin
      repeat (3) begin
        @(negedge clk);
        check_eq("ph_start", bus.o_tx_start, 1);
        check_eq("ph_nodone", bus.o_done, 0);
      end
      txd = 1'b0;
      @(negedge clk);
      check_eq("ph_low_start", bus.o_tx_start, 1);
    end
    if (drop_mid) begin
      req_v[w]  = 1'b0;
      byte_v[w] = ~exp_b;
    end
    for (int unsigned i = 0; i < wait_c; i++) begin
      @(negedge clk);
      check_eq("s_start", bus.o_tx_start, 1);
      check_eq("s_grant", bus.o_grant, oh);
      check_eq("s_data",  bus.o_tx_data, exp_b);
      check_eq("s_nodone", bus.o_done, 0);
    end
    txd = 1'b1;
    @(negedge clk);
    check_eq("c_done",  bus.o_done, oh);
    check_eq("c_start", bus.o_tx_start, 0);
    check_eq("c_busy",  bus.o_busy, 1);
    check_eq("c_timeout", bus.o_timeout, 0);
    txd = 1'b0;
    last_served = w;
    if (!keep_req) req_v[w] = 1'b0;
    @(negedge clk);
    check_idle_outputs("r");
    served = w;
  endtask

  initial begin
    int unsigned served;
    logic [7:0]  sent;
    logic [7:0]  seq2 [4];
    logic [1:0]  nreq;
    int unsigned cnt;
    bit          saw_to;
    bit          saw_done;
    n_tests = 0;
    n_fail  = 0;
    req_v   = '0;
    byte_v[0] = '0;
    byte_v[1] = '0;
    txd     = 1'b0;
    rst     = 1'b0;
    @(negedge clk);
    apply_reset();

    // 1: single request, completion 20 cycles in
    req_v = 2'b01; byte_v[0] = 8'h35;
    do_xfer(0, 0, 0, 20, served, sent);
    check_eq("t1_byte", sent, 8'h35);

    // 2: both held -> alternation from req0
    apply_reset();
    seq2[0] = 8'h31; seq2[1] = 8'h32; seq2[2] = 8'h31; seq2[3] = 8'h32;
    req_v = 2'b11; byte_v[0] = 8'h31; byte_v[1] = 8'h32;
    for (int unsigned i = 0; i < 4; i++) begin
      do_xfer(0, 0, 1, $urandom_range(0, 4), served, sent);
      check_eq("t2_seq", sent, seq2[i]);
    end
    req_v = 2'b00;
    @(negedge clk);

    // 3: tx_done high before the grant
    req_v = 2'b10; byte_v[1] = 8'hA5;
    do_xfer(1, 0, 0, 2, served, sent);

    // 4: reset mid-SEND, req0 first afterwards
    req_v = 2'b01; byte_v[0] = 8'h11;
    do_xfer(0, 0, 0, 1, served, sent);
    req_v = 2'b10; byte_v[1] = 8'h22;
    @(negedge clk);
    check_eq("t4_grant1", bus.o_grant, 2'b10);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("t4_rst");
    check_eq("t4_data", bus.o_tx_data, 0);
    rst = 1'b0;
    last_served = 1;
    req_v = 2'b11;
    do_xfer(0, 0, 0, 3, served, sent);
    check_eq("t4_first", served, 0);
    do_xfer(0, 0, 0, 1, served, sent);
    check_eq("t4_second", served, 1);

    // 5: no tx_done
    req_v = 2'b01; byte_v[0] = 8'h5A;
    served = model_pick(req_v);
    cnt = 0; saw_to = 0; saw_done = 0;
    @(negedge clk);
    while (bus.o_tx_start && cnt < 1000) begin
      cnt++;
      if (bus.o_timeout) saw_to = 1;
      if (bus.o_done != 0) saw_done = 1;
      @(negedge clk);
    end
    check_eq("t5_nodone", saw_done, 0);
`ifdef ARB_TIMEOUT_EN
    check_eq("t5_cycles", cnt, 50);
    check_eq("t5_timeout", bus.o_timeout, 1);
    check_eq("t5_done", bus.o_done, 0);
    check_eq("t5_early_to", saw_to, 0);
    last_served = served;
    req_v = 2'b00;
    @(negedge clk);
    check_idle_outputs("t5_rel");
    check_eq("t5_to_low", bus.o_timeout, 0);
`else
    check_eq("t5_cycles", cnt, 1000);
    check_eq("t5_no_to", saw_to, 0);
    txd = 1'b1;
    @(negedge clk);
    check_eq("t5_done", bus.o_done, 2'b01);
    txd = 1'b0;
    last_served = served;
    req_v = 2'b00;
    @(negedge clk);
    check_idle_outputs("t5_rel");
`endif

    // 6: drop req mid-SEND, then stay idle
    req_v = 2'b01; byte_v[0] = 8'h66;
    do_xfer(0, 1, 0, 3, served, sent);
    check_eq("t6_byte", sent, 8'h66);
    repeat (4) begin
      @(negedge clk);
      check_idle_outputs("t6_idle");
    end

    // Randomized traffic
    for (int unsigned it = 0; it < 40; it++) begin
      if (req_v == 2'b00) begin
        repeat ($urandom_range(0, 3)) begin
          @(negedge clk);
          check_eq("g_busy", bus.o_busy, 0);
        end
      end
      nreq = 2'($urandom_range(0, 3));
      if (req_v == 2'b00 && nreq == 2'b00) nreq = 2'($urandom_range(1, 3));
      for (int unsigned k = 0; k < 2; k++) begin
        if (nreq[k] && !req_v[k]) begin
          byte_v[k] = 8'($urandom);
          req_v[k]  = 1'b1;
        end
      end
      do_xfer(($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
              ($urandom_range(0, 1) == 1), $urandom_range(0, 6), served, sent);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
